// File: rtl/gals_sched_pkg.sv
// Shared encodings for the GALS timestep scheduler: FSM states and the
// error codes reported to the host/control layer.
package gals_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PE_REQ   = 4'd1,
    S_PE_REL   = 4'd2,
    S_COLL_REQ = 4'd3,
    S_COLL_GAP = 4'd4,
    S_DONE     = 4'd5,
    S_ERROR    = 4'd6
  } sched_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_PE_TIMEOUT = 2'b01,
    ERR_COLL       = 2'b10,
    ERR_ABORT      = 2'b11
  } sched_err_e;

  // True in states where abort and collector error are honoured.
  function automatic logic is_run_state(input sched_state_e st);
    return (st != S_IDLE) && (st != S_ERROR);
  endfunction

endpackage

// File: rtl/sync_2ff_vec.sv
// Two-flop synchronizer for a vector of independent asynchronous levels.
// Each bit is synchronized on its own; no cross-bit coherency is implied.
module sync_2ff_vec #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_d;

  // Next values of the two synchronizer stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer stages, cleared by the shared asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {W{1'b0}};
      sync_q <= {W{1'b0}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gals_timestep_scheduler.sv
// Sequences one inference run of NUM_TIMESTEPS timesteps: broadcast 4-phase
// start handshake to the PE array, then one AER request to the collector,
// then wait for its ack. Errors (PE timeout, collector, abort) are latched.
module gals_timestep_scheduler
  import gals_sched_pkg::*;
#(
  parameter int NUM_TIMESTEPS = 16,
  parameter int PE_COUNT      = 64,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                               local_clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic                               i_abort,
  input  logic                               i_clear,
  output logic                               o_pe_start_req,
  input  logic [PE_COUNT-1:0]                i_pe_start_ack_vec,
  output logic                               o_aer_req,
  input  logic                               i_aer_ack,
  input  logic                               i_coll_error,
  output logic [$clog2(NUM_TIMESTEPS):0]     o_timestep,
  output logic                               o_done,
  output logic [1:0]                         o_err_code,
  output logic                               o_error,
  output logic                               o_busy
);

  localparam int TS_W = $clog2(NUM_TIMESTEPS) + 1;
  localparam int WD_W = $clog2(START_TIMEOUT) + 1;

  localparam logic [TS_W-1:0] TS_LAST  = TS_W'(NUM_TIMESTEPS - 1);
  localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(START_TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

  sched_state_e   state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  sched_err_e     err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [PE_COUNT-1:0] ack_sync_s;
  logic                ack_all_s;
  logic                ack_none_s;
  logic [WD_W-1:0]     wd_inc_s;
  logic                wd_expired_s;

  logic pe_req_s, aer_req_s, done_s, error_s, busy_s;

  sync_2ff_vec #(
    .W (PE_COUNT)
  ) u_ack_sync (
    .clk   (local_clk),
    .rst_n (rst_n),
    .d_i   (i_pe_start_ack_vec),
    .q_o   (ack_sync_s)
  );

  assign ack_all_s  = &ack_sync_s;
  assign ack_none_s = ~(|ack_sync_s);

  // Saturating watchdog increment and its expiry flag for the handshake phases.
  always_comb begin
    if (wd_q == WD_MAX) begin
      wd_inc_s = wd_q;
    end else begin
      wd_inc_s = wd_q + WD_ONE;
    end
    wd_expired_s = (wd_inc_s >= WD_LIMIT);
  end

  // State, timestep, error code and watchdog registers.
  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ts_q    <= {TS_W{1'b0}};
      err_q   <= ERR_NONE;
      wd_q    <= {WD_W{1'b0}};
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic; handshake completion beats timeout, errors beat progress.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    err_d   = err_q;
    wd_d    = {WD_W{1'b0}};

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_PE_REQ;
          ts_d    = {TS_W{1'b0}};
          err_d   = ERR_NONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PE_REQ: begin
        if (ack_all_s) begin
          state_d = S_PE_REL;
        end else if (wd_expired_s) begin
          state_d = S_ERROR;
          err_d   = ERR_PE_TIMEOUT;
        end else begin
          wd_d = wd_inc_s;
        end
      end
      S_PE_REL: begin
        if (ack_none_s) begin
          state_d = S_COLL_REQ;
        end else if (wd_expired_s) begin
          state_d = S_ERROR;
          err_d   = ERR_PE_TIMEOUT;
        end else begin
          wd_d = wd_inc_s;
        end
      end
      S_COLL_REQ: begin
        // No local timeout: the collector's own watchdog covers this wait.
        if (i_aer_ack) begin
          state_d = S_COLL_GAP;
        end else begin
          state_d = S_COLL_REQ;
        end
      end
      S_COLL_GAP: begin
        // Request is low here for one cycle so the collector sees it drop.
        if (ts_q == TS_LAST) begin
          state_d = S_DONE;
        end else begin
          ts_d    = ts_q + TS_ONE;
          state_d = S_PE_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (i_clear) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (is_run_state(state_q)) begin
      if (i_abort) begin
        state_d = S_ERROR;
        err_d   = ERR_ABORT;
        wd_d    = {WD_W{1'b0}};
      end else if (i_coll_error) begin
        state_d = S_ERROR;
        err_d   = ERR_COLL;
        wd_d    = {WD_W{1'b0}};
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the state register only (no input-to-output path).
  always_comb begin
    pe_req_s  = 1'b0;
    aer_req_s = 1'b0;
    done_s    = 1'b0;
    error_s   = 1'b0;
    busy_s    = 1'b1;
    case (state_q)
      S_IDLE:     busy_s    = 1'b0;
      S_PE_REQ:   pe_req_s  = 1'b1;
      S_PE_REL:   pe_req_s  = 1'b0;
      S_COLL_REQ: aer_req_s = 1'b1;
      S_COLL_GAP: aer_req_s = 1'b0;
      S_DONE:     done_s    = 1'b1;
      S_ERROR:    error_s   = 1'b1;
      default:    busy_s    = 1'b1;
    endcase
  end

  assign o_pe_start_req = pe_req_s;
  assign o_aer_req      = aer_req_s;
  assign o_done         = done_s;
  assign o_error        = error_s;
  assign o_busy         = busy_s;
  assign o_timestep     = ts_q;
  assign o_err_code     = err_q;

endmodule

// File: tb/tb_gals_timestep_scheduler.sv
// Directed bench for gals_timestep_scheduler. Timesteps expected at each AER
// request are queued when a run is started and popped when the request rises.
module tb_gals_timestep_scheduler;

  localparam int NTS = 3;
  localparam int NPE = 4;
  localparam int TMO = 32;
  localparam int TSW = $clog2(NTS) + 1;

  logic           local_clk = 1'b0;
  logic           rst_n;
  logic           i_start, i_abort, i_clear, i_aer_ack, i_coll_error;
  logic [NPE-1:0] i_pe_start_ack_vec;
  logic           o_pe_start_req, o_aer_req, o_done, o_error, o_busy;
  logic [TSW-1:0] o_timestep;
  logic [1:0]     o_err_code;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int exp_ts_q[$];

  gals_timestep_scheduler #(
    .NUM_TIMESTEPS (NTS),
    .PE_COUNT      (NPE),
    .START_TIMEOUT (TMO)
  ) dut (
    .local_clk          (local_clk),
    .rst_n              (rst_n),
    .i_start            (i_start),
    .i_abort            (i_abort),
    .i_clear            (i_clear),
    .o_pe_start_req     (o_pe_start_req),
    .i_pe_start_ack_vec (i_pe_start_ack_vec),
    .o_aer_req          (o_aer_req),
    .i_aer_ack          (i_aer_ack),
    .i_coll_error       (i_coll_error),
    .o_timestep         (o_timestep),
    .o_done             (o_done),
    .o_err_code         (o_err_code),
    .o_error            (o_error),
    .o_busy             (o_busy)
  );

  always #5 local_clk = ~local_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge local_clk);
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return o_pe_start_req;
      1:       return o_aer_req;
      2:       return o_done;
      default: return o_error;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int budget, input string tag);
    int k = 0;
    while ((sel_sig(sel) !== lvl) && (k < budget)) begin
      step(1);
      k++;
    end
    check(tag, 32'(sel_sig(sel)), 32'(lvl));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pe_req"}, 32'(o_pe_start_req), 32'd0);
    check({tag, "_aer_req"}, 32'(o_aer_req), 32'd0);
    check({tag, "_ts"}, 32'(o_timestep), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err_code"}, 32'(o_err_code), 32'd0);
    check({tag, "_error"}, 32'(o_error), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // PE array: all ack a couple of cycles after req, release after req drops.
  task automatic pe_hs();
    wait_for(0, 1'b1, 40, "pe_req_rise");
    step(2);
    i_pe_start_ack_vec = {NPE{1'b1}};
    wait_for(0, 1'b0, 40, "pe_req_fall");
    step(1);
    i_pe_start_ack_vec = {NPE{1'b0}};
  endtask

  // Wait for the AER request, score the timestep, then idle until ack time.
  task automatic coll_req_wait();
    logic [31:0] exp;
    wait_for(1, 1'b1, 40, "aer_req_rise");
    if (exp_ts_q.size() > 0) exp = 32'(exp_ts_q.pop_front());
    else exp = 32'hDEAD;
    check("ts_at_aer_req", 32'(o_timestep), exp);
    step(9);
  endtask

  task automatic coll_ack(input logic with_err);
    i_aer_ack    = 1'b1;
    i_coll_error = with_err;
    step(1);
    i_aer_ack    = 1'b0;
    i_coll_error = 1'b0;
    check("aer_req_low_after_ack", 32'(o_aer_req), 32'd0);
  endtask

  task automatic run_ts(input int ts, input bit last);
    pe_hs();
    coll_req_wait();
    coll_ack(1'b0);
    step(1);
    check("aer_req_still_low", 32'(o_aer_req), 32'd0);
    if (last) begin
      check("done_pulse", 32'(o_done), 32'd1);
      check("ts_at_done", 32'(o_timestep), 32'(ts));
      step(1);
      check("done_one_cycle", 32'(o_done), 32'd0);
      check("busy_after_done", 32'(o_busy), 32'd0);
      check("ts_hold_after_done", 32'(o_timestep), 32'(ts));
    end else begin
      check("no_early_done", 32'(o_done), 32'd0);
      check("next_pe_req", 32'(o_pe_start_req), 32'd1);
    end
  endtask

  task automatic start_run();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic clear_error();
    i_pe_start_ack_vec = {NPE{1'b0}};
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    check("clear_error", 32'(o_error), 32'd0);
    check("clear_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_clear = 1'b0;
    i_aer_ack = 1'b0; i_coll_error = 1'b0;
    i_pe_start_ack_vec = {NPE{1'b0}};
    step(2);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // Full 3-timestep run.
    exp_ts_q.push_back(0); exp_ts_q.push_back(1); exp_ts_q.push_back(2);
    start_run();
    check("start_latency_pe_req", 32'(o_pe_start_req), 32'd1);
    check("busy_after_start", 32'(o_busy), 32'd1);
    for (int t = 0; t < NTS; t++) run_ts(t, t == NTS - 1);

    // One PE never acks: timeout after exactly TMO cycles in S_PE_REQ.
    start_run();
    i_pe_start_ack_vec = 4'b1110;
    step(TMO - 1);
    check("no_timeout_before_limit", 32'(o_error), 32'd0);
    check("pe_req_before_limit", 32'(o_pe_start_req), 32'd1);
    step(1);
    check("timeout_error", 32'(o_error), 32'd1);
    check("timeout_code", 32'(o_err_code), 32'd1);
    check("timeout_pe_req", 32'(o_pe_start_req), 32'd0);
    check("timeout_aer_req", 32'(o_aer_req), 32'd0);
    clear_error();

    // Collector error coincident with ack at timestep 1.
    exp_ts_q.push_back(0); exp_ts_q.push_back(1);
    start_run();
    run_ts(0, 1'b0);
    pe_hs();
    coll_req_wait();
    coll_ack(1'b1);
    check("coll_err_error", 32'(o_error), 32'd1);
    check("coll_err_code", 32'(o_err_code), 32'd2);
    check("coll_err_ts", 32'(o_timestep), 32'd1);
    check("coll_err_no_done", 32'(o_done), 32'd0);
    i_start = 1'b1; i_abort = 1'b1; i_coll_error = 1'b1;
    step(1);
    i_start = 1'b0; i_abort = 1'b0; i_coll_error = 1'b0;
    check("error_ignores_inputs_code", 32'(o_err_code), 32'd2);
    check("error_ignores_inputs_err", 32'(o_error), 32'd1);
    clear_error();

    // Abort while in S_PE_REL at timestep 2.
    exp_ts_q.push_back(0); exp_ts_q.push_back(1);
    start_run();
    run_ts(0, 1'b0);
    run_ts(1, 1'b0);
    wait_for(0, 1'b1, 40, "pe_req_rise_ts2");
    check("ts2_before_abort", 32'(o_timestep), 32'd2);
    i_pe_start_ack_vec = {NPE{1'b1}};
    wait_for(0, 1'b0, 40, "pe_req_fall_ts2");
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    check("abort_error", 32'(o_error), 32'd1);
    check("abort_code", 32'(o_err_code), 32'd3);
    clear_error();

    // Restart after abort, then asynchronous reset in S_COLL_REQ.
    exp_ts_q.push_back(0);
    start_run();
    check("restart_ts", 32'(o_timestep), 32'd0);
    check("restart_code_cleared", 32'(o_err_code), 32'd0);
    check("restart_pe_req", 32'(o_pe_start_req), 32'd1);
    pe_hs();
    coll_req_wait();
    check("aer_req_before_reset", 32'(o_aer_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    step(1);
    rst_n = 1'b1;
    step(1);

    // Fresh run after reset.
    exp_ts_q.push_back(0); exp_ts_q.push_back(1); exp_ts_q.push_back(2);
    start_run();
    check("post_reset_pe_req", 32'(o_pe_start_req), 32'd1);
    for (int t = 0; t < NTS; t++) run_ts(t, t == NTS - 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
